// File: rtl/rfifo_pkg.sv
// Shared types and helpers for the rfifo read-side burst scheduler.
package rfifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_ctrl_state_t;

  function automatic int rd_beat_bytes(input int data_width);
    return data_width / 8;
  endfunction

  // Two spare bits let level + inflight + one burst sum without overflow.
  function automatic int rd_credit_width(input int fifo_depth);
    return $clog2(fifo_depth) + 2;
  endfunction

endpackage

// File: rtl/rfifo_rd_ctrl_if.sv
// Memory read channel (AR/R) plus FIFO write port seen by rfifo_rd_ctrl.
interface rfifo_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 256
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Handshake: a transfer happens on a rising clock edge where valid and ready
  // are both high; once valid is raised, its payload stays stable until then.
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_rvalid;
  logic                  m_rlast;
  logic                  m_rready;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic [LVL_W-1:0]      fifo_wr_level;

  modport master (
    output m_araddr, m_arlen, m_arvalid, m_rready, fifo_wr_en, fifo_wr_data,
    input  m_arready, m_rdata, m_rvalid, m_rlast, fifo_wr_level
  );

  modport slave (
    input  m_araddr, m_arlen, m_arvalid, m_rready, fifo_wr_en, fifo_wr_data,
    output m_arready, m_rdata, m_rvalid, m_rlast, fifo_wr_level
  );

endinterface

// File: rtl/rd_credit_cnt.sv
// Beats-in-flight and bursts-outstanding counters with the AR issue gate.
module rd_credit_cnt
  import rfifo_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 256,
  parameter int MAX_OUTST  = 4,
  localparam int CW        = rd_credit_width(FIFO_DEPTH),
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ar_fire_i,
  input  logic             r_beat_i,
  input  logic             r_last_i,
  input  logic [LVL_W-1:0] fifo_level_i,
  output logic             issue_ok_o,
  output logic [CW-1:0]    inflight_o,
  output logic [3:0]       outst_o,
  output logic [3:0]       outst_d_o
);

  logic [CW-1:0] inflight_q, inflight_d;
  logic [3:0]    outst_q, outst_d;

  // AR handshake and R beat in the same cycle apply both updates.
  always_comb begin
    inflight_d = inflight_q;
    outst_d    = outst_q;
    if (ar_fire_i) begin
      inflight_d = inflight_d + CW'(BURST_LEN);
      outst_d    = outst_d + 4'd1;
    end
    if (r_beat_i && inflight_d != '0) begin
      inflight_d = inflight_d - CW'(1);
    end
    if (r_beat_i && r_last_i && outst_d != '0) begin
      outst_d = outst_d - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      outst_q    <= '0;
    end else begin
      inflight_q <= inflight_d;
      outst_q    <= outst_d;
    end
  end

  assign issue_ok_o = ((CW'(fifo_level_i) + inflight_q + CW'(BURST_LEN)) <= CW'(FIFO_DEPTH))
                      && (outst_q < 4'(MAX_OUTST));
  assign inflight_o = inflight_q;
  assign outst_o    = outst_q;
  assign outst_d_o  = outst_d;

endmodule

// File: rtl/rfifo_rd_ctrl.sv
// Frame read-burst scheduler: issues AR bursts only with guaranteed FIFO room.
// Define RFIFO_RD_CTRL_ERR_CHK_EN to build the sticky err output and its checker.
module rfifo_rd_ctrl
  import rfifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 256,
  parameter int MAX_OUTST  = 4
) (
  input  logic                              wr_clk,
  input  logic                              wr_rst,
  input  logic                              start,
  input  logic                              stop,
  input  logic [ADDR_WIDTH-1:0]             frame_base,
  input  logic [15:0]                       frame_bursts,
  output logic                              busy,
  output logic                              frame_done,
`ifdef RFIFO_RD_CTRL_ERR_CHK_EN
  output logic                              err,
`endif
  output rd_ctrl_state_t                    dbg_state_o,
  output logic [rd_credit_width(FIFO_DEPTH)-1:0] dbg_inflight_o,
  output logic [3:0]                        dbg_outst_o,
  rfifo_rd_ctrl_if.master                   bus
);

  localparam int CW            = rd_credit_width(FIFO_DEPTH);
  localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1;
  localparam int RD_BEAT_BYTES = rd_beat_bytes(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] BURST_STRIDE = ADDR_WIDTH'(BURST_LEN * RD_BEAT_BYTES);

  rd_ctrl_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           total_q, total_d;
  logic [15:0]           issued_q, issued_d;
  logic                  arvalid_q, arvalid_d;
  logic                  aborted_q, aborted_d;
  logic                  done_q, done_d;

  logic                  ar_fire;
  logic                  r_beat;
  logic                  issue_ok;
  logic [CW-1:0]         inflight;
  logic [3:0]            outst;
  logic [3:0]            outst_d;

  assign ar_fire           = arvalid_q & bus.m_arready;
  assign bus.m_rready      = ~wr_rst;
  assign r_beat            = bus.m_rvalid & bus.m_rready;
  assign bus.fifo_wr_en    = r_beat;
  assign bus.fifo_wr_data  = bus.m_rdata;
  assign bus.m_arlen       = 8'(BURST_LEN - 1);
  assign bus.m_araddr      = addr_q;
  assign bus.m_arvalid     = arvalid_q;

  assign busy           = (state_q != ST_IDLE);
  assign frame_done     = done_q;
  assign dbg_state_o    = state_q;
  assign dbg_inflight_o = inflight;
  assign dbg_outst_o    = outst;

  rd_credit_cnt #(
    .BURST_LEN  (BURST_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_OUTST  (MAX_OUTST)
  ) u_credit (
    .clk_i        (wr_clk),
    .rst_i        (wr_rst),
    .ar_fire_i    (ar_fire),
    .r_beat_i     (r_beat),
    .r_last_i     (bus.m_rlast),
    .fifo_level_i (bus.fifo_wr_level),
    .issue_ok_o   (issue_ok),
    .inflight_o   (inflight),
    .outst_o      (outst),
    .outst_d_o    (outst_d)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    total_d   = total_q;
    issued_d  = issued_q;
    arvalid_d = arvalid_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;

    // A raised AR is never withdrawn, even by stop; it only drops on handshake.
    if (ar_fire) begin
      addr_d    = addr_q + BURST_STRIDE;
      issued_d  = issued_q + 16'd1;
      arvalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ISSUE;
          addr_d    = frame_base;
          total_d   = (frame_bursts == 16'd0) ? 16'd1 : frame_bursts;
          issued_d  = '0;
          aborted_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (issued_d == total_q) begin
          state_d = ST_DRAIN;
        end else if (!arvalid_q && issue_ok) begin
          arvalid_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (stop) begin
          aborted_d = 1'b1;
        end
        if (outst_d == 4'd0 && !arvalid_q) begin
          state_d = ST_IDLE;
          done_d  = !(aborted_q || stop);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      total_q   <= '0;
      issued_q  <= '0;
      arvalid_q <= 1'b0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      total_q   <= total_d;
      issued_q  <= issued_d;
      arvalid_q <= arvalid_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
    end
  end

`ifdef RFIFO_RD_CTRL_ERR_CHK_EN
  logic       err_q, err_d;
  logic [7:0] beat_idx_q, beat_idx_d;

  // beat_idx_q is the zero-based position of the current beat within its burst.
  always_comb begin
    err_d      = err_q;
    beat_idx_d = beat_idx_q;
    if (r_beat) begin
      beat_idx_d = bus.m_rlast ? 8'd0 : beat_idx_q + 8'd1;
      if (bus.m_rlast && beat_idx_q != 8'(BURST_LEN - 1)) begin
        err_d = 1'b1;
      end
      if (bus.fifo_wr_level >= LVL_W'(FIFO_DEPTH)) begin
        err_d = 1'b1;
      end
      if (inflight == '0) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      err_q      <= 1'b0;
      beat_idx_q <= '0;
    end else begin
      err_q      <= err_d;
      beat_idx_q <= beat_idx_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: doc/rfifo_rd_ctrl.md
# rfifo_rd_ctrl

Read-burst scheduler that fills the `rfifo` read-data FIFO from external memory over an AXI-style read channel. It walks one frame of consecutive bursts from a programmed base address. An AR burst is issued only when FIFO space for the whole burst is already guaranteed, counting both the current FIFO level and all beats still in flight. This lets R data stream into the FIFO with `m_rready` held high. The block sits in the FIFO write-clock domain, between the memory interface and the FIFO write port.

## Interface
- `ADDR_WIDTH`, 28, byte address width
- `DATA_WIDTH`, 32, beat width; equals FIFO write width
- `BURST_LEN`, 16, beats per burst (power of 2, 1..256)
- `FIFO_DEPTH`, 256, FIFO capacity in words
- `MAX_OUTST`, 4, max AR bursts outstanding (1..15)

- `wr_clk`  in  1  clock (FIFO write clock)
- `wr_rst`  in  1  reset; **one clock; reset is synchronous and active-high**
- `start`  in  1  pulse; begins a frame when idle
- `stop`  in  1  pulse; abort, drain in-flight bursts
- `frame_base`  in  ADDR_WIDTH  frame start byte address, sampled on accepted `start`
- `frame_bursts`  in  16  bursts per frame, sampled on `start`; 0 treated as 1
- `busy`  out  1  high from accepted `start` until return to IDLE
- `frame_done`  out  1  one-cycle pulse, frame fully written to FIFO
- `m_araddr`  out  ADDR_WIDTH  burst address
- `m_arlen`  out  8  constant BURST_LEN-1
- `m_arvalid`  out  1  AR valid
- `m_arready`  in  1  AR ready
- `m_rdata`  in  DATA_WIDTH  read data
- `m_rvalid`  in  1  R valid
- `m_rlast`  in  1  last beat of burst
- `m_rready`  out  1  R ready
- `fifo_wr_en`  out  1  FIFO write enable
- `fifo_wr_data`  out  DATA_WIDTH  FIFO write data
- `fifo_wr_level`  in  $clog2(FIFO_DEPTH)+1  FIFO write water level; reflects a write on the cycle after `fifo_wr_en`
- `err`  out  1  sticky error; present only with the macro

## Operation
- States: IDLE, ISSUE, DRAIN.
  - IDLE→ISSUE on `start`.
  - ISSUE→DRAIN when all bursts of the frame are issued, or on `stop`.
  - DRAIN→IDLE when the outstanding burst count reaches 0.
  - `start` outside IDLE is ignored.
- Credit check: `inflight` counts beats requested but not yet written.
  - Issue allowed when `fifo_wr_level + inflight + BURST_LEN <= FIFO_DEPTH` and `outst < MAX_OUTST`.
  - Compare at width $clog2(FIFO_DEPTH)+2 so the sum cannot overflow.
- AR handshake:
  - `m_arvalid` rises only when the credit check passes.
  - Once high, `m_araddr` and `m_arvalid` stay stable until `m_arready`.
  - On the handshake: `inflight += BURST_LEN`, `outst += 1`, address `+= BURST_LEN*DATA_WIDTH/8`, issued-burst counter `+= 1`.
- Address arithmetic: the address wraps modulo 2^ADDR_WIDTH. No 4 KB split is performed; software aligns `frame_base` to the burst size.
- R path:
  - `m_rready` = 1 whenever not in reset.
  - `fifo_wr_en = m_rvalid`, `fifo_wr_data = m_rdata`; both combinational.
  - Each beat decrements `inflight`.
  - A beat with `m_rlast` decrements `outst`.
  - A simultaneous AR handshake and R beat apply both updates in the same cycle.
- `frame_done` fires when, not aborted by `stop`, the final burst's `m_rlast` beat is accepted; then return to IDLE.
- `stop`:
  - Suppresses new AR issues. An AR already asserted completes its handshake.
  - Bursts still in flight are absorbed into the FIFO.
  - No `frame_done` is generated.
- Reset mid-operation: all counters and state clear. The memory-side agent is reset on the same `wr_rst`.

## Timing
- Reset values: `busy`=0, `frame_done`=0, `m_arvalid`=0, `m_araddr`=0, `m_rready`=0, `fifo_wr_en`=0, `err`=0.
- `start` at cycle T:
  - `busy`=1 at T+1.
  - First `m_arvalid` at T+2 if the credit check passes.
- AR issue rate: at most one burst per 2 cycles. The credit check is re-evaluated the cycle after each handshake.
- R→FIFO latency: 0 cycles, combinational.
- `frame_done`: the cycle after the last `m_rlast` beat. `busy` falls in the same cycle.

## Configuration
- `RFIFO_RD_CTRL_ERR_CHK_EN` defined: the `err` port and checker logic are compiled in. `err` sets, and holds until `wr_rst`, on any of:
  - `m_rvalid` while `fifo_wr_full`
  - `m_rvalid` while `inflight`==0
  - `m_rlast` on a beat other than the BURST_LEN-th beat of a burst
- Macro undefined: no `err` port, no checker logic; behaviour is otherwise identical.

## Structure
- Shared package `rfifo_pkg`:
  - state enum `rd_ctrl_state_t`
  - `RD_BEAT_BYTES` localparam function
  - credit-width helper
- One sub-module `rd_credit_cnt`: holds the `inflight`/`outst` counters and the issue-allowed compare.

## Test plan
- Reset, then `start` with base 0x0000100, 4 bursts, fast slave → ARs at 0x100/0x140/0x180/0x1C0, 64 FIFO writes, one `frame_done`.
- `fifo_wr_level`=241, `inflight`=0 → no AR issued. Level drops to 240 → AR issued 2 cycles later.
- Slave withholds R until 4 ARs are issued → 5th AR held off (MAX_OUTST). First `m_rlast` → next AR follows.
- `stop` mid-frame with 3 bursts in flight → no new AR, 48 beats written, `busy` drops, no `frame_done`.
- `m_arready` held low 10 cycles → `m_araddr`/`m_arvalid` stable throughout. AR handshake coincident with an R beat → counters correct.
- Macro on, `m_rlast` injected at beat 8 → `err`=1 from the next cycle, held until `wr_rst`.
